exec_datapath_p: RTL
====================

// Module: exec_datapath_p
// PURPOSE
//  Parametrised execute datapath: register file, operand mux, ALU and registered EX output stage.
//  Inputs: an operand-fetch/issue handshake and an external write-back port.
//  Outputs: a valid/ready result with status flags and store data (rs2) for the memory stage.
//  Adds to the single-cycle datapath: width/depth parameters, WB->read bypass, output backpressure.
//  Adds optional iterative multiplier.
// PARAMETERS
//  XLEN    32                    data/register width (>=8, power of 2)
//  NREGS   32                    register count (power of 2); register 0 reads as zero
//  REG_AW  $clog2(NREGS)         register index width (derived, localparam)
// PORTS
//  clk          in   1       single clock, all state on rising edge
//  rst          in   1       asynchronous, active-high reset
//  in_valid     in   1       issue request
//  in_ready     out  1       issue accepted when in_valid & in_ready at clk edge
//  alu_control  in   4       opcode (dpath_pkg::alu_op_e)
//  alu_source   in   1       1: B=rs2 value, 0: B=immediate
//  rs_1, rs_2   in   REG_AW  source register indices
//  rd_0         in   REG_AW  destination index, carried to rd_out
//  immediate    in   XLEN    immediate operand
//  write_rb     in   1       write-back enable
//  wb_rd        in   REG_AW  write-back index
//  writedata    in   XLEN    write-back data
//  out_valid    out  1       result valid
//  out_ready    in   1       consumer accepts result
//  alu_result   out  XLEN    registered result
//  rs2          out  XLEN    registered rs2 value (store data)
//  rd_out       out  REG_AW  registered destination index
//  negative, overflow, zero  out 1 each  registered flags
// BEHAVIOUR
//  Reset: all registers incl. file = 0; out_valid=0; alu_result/rs2/rd_out/flags=0; FSM=IDLE.
//  in_ready (comb) = (state==IDLE) && (!out_valid || out_ready); it is 1 out of reset.
//  Register read is combinational. Index 0 always reads 0.
//  Bypass: if write_rb && wb_rd==rs_x && wb_rd!=0, the read returns writedata in the same cycle.
//  Write: on write_rb at clk edge; wb_rd==0 ignored.
//  Ops 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU.
//  SLT/SLTU: result is 0 or 1. Ops 10 MUL (see CONFIGURATION) and 11-15: result 0.
//  Shift amount = B[$clog2(XLEN)-1:0]. All arithmetic modulo 2^XLEN.
//  Flags: negative=result[XLEN-1]; zero=(result==0).
//  overflow = signed overflow for ADD/SUB only, else 0.
//  Single-cycle ops: accepted at edge N -> out_valid=1 with result, flags, rs2, rd_out after edge N.
//  Output stage holds all outputs stable while out_valid && !out_ready.
//  Output clears out_valid on handshake unless a new result loads in the same edge (back-to-back, 1/clk).
//  Reset mid-operation: immediate abort to IDLE; no partial result emitted.
// CONFIGURATION
//  Macro DPATH_MUL_EN defined: op 10 = MUL, low XLEN bits of A*B. Shift-add iterative multiplier.
//   FSM: IDLE -(accept MUL)-> MUL, XLEN iterations, counter 0..XLEN-1 -> LOAD -> IDLE.
//   LOAD writes the output stage. out_valid rises XLEN+1 edges after accept.
//   in_ready=0 in MUL and LOAD. Flags for MUL: negative, zero as above; overflow=0.
//   Operands are latched at accept, so later write-back does not affect the product.
//  Not defined: op 10 behaves as illegal (result 0, single cycle). No FSM/multiplier logic.
//   State stays IDLE.
// STRUCTURE
//  dpath_pkg: alu_op_e enum (4-bit codes above), dp_state_e {IDLE,MUL,LOAD}, ALU flag struct.
//  Sub-module regfile_bypass #(XLEN,NREGS): 2R1W array, reset clear, r0=0, WB bypass.
//  ALU, FSM, multiplier and output register live in exec_datapath_p.
// TESTING
//  1 Reset: assert rst mid-stream -> out_valid=0, all outputs 0, in_ready=1; x1 reads 0 afterwards.
//  2 WB x5=7, then ADD rs1=x5, imm=3, alu_source=0 -> alu_result=10, zero=0, rd_out as issued.
//  3 Same-cycle write_rb x6=0x8000_0000 and issue ADD x6+x6 (alu_source=1) -> result=0, zero=1, overflow=1.
//  4 Backpressure: out_ready=0 for 3 cycles after a SUB 5-7 -> in_ready=0.
//    Outputs hold 0xFFFF_FFFE, negative=1. out_ready=1 -> next op issues same edge.
//  5 WB to x0 value 9, then OR x0|imm 0 -> result 0, zero=1.
//    SRA 0x8000_0000 by 4 -> 0xF800_0000. SLTU 1<0xFFFF_FFFF -> 1.
//  6 With DPATH_MUL_EN: MUL 0x1234*0x10, out_valid exactly 33 edges after accept, result 0x12340.
//    in_ready=0 throughout. Reset at cycle 10 -> aborts. Without macro: op 10 -> 0 in 1 cycle.

Source files
------------

// File: rtl/dpath_pkg.sv
// Shared types for the execute datapath: ALU opcodes, FSM states, flags.
// Imported by regfile_bypass and exec_datapath_p.
package dpath_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_XOR  = 4'd4,
    OP_SLL  = 4'd5,
    OP_SRL  = 4'd6,
    OP_SRA  = 4'd7,
    OP_SLT  = 4'd8,
    OP_SLTU = 4'd9,
    OP_MUL  = 4'd10
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    LOAD = 2'd2
  } dp_state_e;

  typedef struct packed {
    logic negative;
    logic overflow;
    logic zero;
  } alu_flags_t;

endpackage

// File: rtl/exec_datapath_p_regfile_bypass.sv
// Two-read one-write register file with x0 hardwired to zero and a
// write-back bypass so a same-cycle write is visible to the readers.
module regfile_bypass #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   ra1,
  input  logic [AW-1:0]   ra2,
  input  logic            we,
  input  logic [AW-1:0]   wa,
  input  logic [XLEN-1:0] wd,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2
);

  logic [XLEN-1:0] regs [NREGS];

  // Register array: cleared on reset, writes to x0 dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (we && wa != '0) begin
      regs[wa] <= wd;
    end
  end

  assign rd1 = (ra1 == '0) ? '0 :
               (we && wa == ra1) ? wd : regs[ra1];
  assign rd2 = (ra2 == '0) ? '0 :
               (we && wa == ra2) ? wd : regs[ra2];

endmodule

// File: rtl/exec_datapath_p.sv
// Execute datapath: regfile, operand mux, ALU, registered EX output stage.
// Optional shift-add multiplier on op 10 when DPATH_MUL_EN is defined.
module exec_datapath_p
  import dpath_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int NREGS   = 32,
  localparam int REG_AW = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        alu_control,
  input  logic              alu_source,
  input  logic [REG_AW-1:0] rs_1,
  input  logic [REG_AW-1:0] rs_2,
  input  logic [REG_AW-1:0] rd_0,
  input  logic [XLEN-1:0]   immediate,
  input  logic              write_rb,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [XLEN-1:0]   writedata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   alu_result,
  output logic [XLEN-1:0]   rs2,
  output logic [REG_AW-1:0] rd_out,
  output logic              negative,
  output logic              overflow,
  output logic              zero
);

  localparam int SHW = $clog2(XLEN);

  logic [XLEN-1:0]   rs1_val;
  logic [XLEN-1:0]   rs2_val;
  logic [XLEN-1:0]   op_b;
  logic [XLEN-1:0]   alu_res;
  logic [XLEN-1:0]   sum;
  logic [XLEN-1:0]   diff;
  logic [SHW-1:0]    shamt;
  alu_flags_t        alu_flags;
  alu_op_e           op;
  dp_state_e         state;
  logic              accept;
  logic              load;
  logic [XLEN-1:0]   ld_res;
  logic [XLEN-1:0]   ld_rs2;
  logic [REG_AW-1:0] ld_rd;
  alu_flags_t        ld_flags;

  regfile_bypass #(
    .XLEN  (XLEN),
    .NREGS (NREGS)
  ) u_rf (
    .clk (clk),
    .rst (rst),
    .ra1 (rs_1),
    .ra2 (rs_2),
    .we  (write_rb),
    .wa  (wb_rd),
    .wd  (writedata),
    .rd1 (rs1_val),
    .rd2 (rs2_val)
  );

  assign op       = alu_op_e'(alu_control);
  assign op_b     = alu_source ? rs2_val : immediate;
  assign sum      = rs1_val + op_b;
  assign diff     = rs1_val - op_b;
  assign shamt    = op_b[SHW-1:0];
  assign in_ready = (state == IDLE) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  // ALU result and flags for single-cycle ops; unknown codes give 0.
  always_comb begin
    alu_res            = '0;
    alu_flags.overflow = 1'b0;
    unique case (op)
      OP_ADD: begin
        alu_res = sum;
        alu_flags.overflow = (rs1_val[XLEN-1] == op_b[XLEN-1]) &&
                             (sum[XLEN-1] != rs1_val[XLEN-1]);
      end
      OP_SUB: begin
        alu_res = diff;
        alu_flags.overflow = (rs1_val[XLEN-1] != op_b[XLEN-1]) &&
                             (diff[XLEN-1] != rs1_val[XLEN-1]);
      end
      OP_AND:  alu_res = rs1_val & op_b;
      OP_OR:   alu_res = rs1_val | op_b;
      OP_XOR:  alu_res = rs1_val ^ op_b;
      OP_SLL:  alu_res = rs1_val << shamt;
      OP_SRL:  alu_res = rs1_val >> shamt;
      OP_SRA:  alu_res = $signed(rs1_val) >>> shamt;
      OP_SLT:  alu_res = {{(XLEN-1){1'b0}},
                          $signed(rs1_val) < $signed(op_b)};
      OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, rs1_val < op_b};
      default: alu_res = '0;
    endcase
    alu_flags.negative = alu_res[XLEN-1];
    alu_flags.zero     = (alu_res == '0);
  end

`ifdef DPATH_MUL_EN
  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] CNT_LAST = CW'(XLEN - 1);

  logic [XLEN-1:0]   mcand;
  logic [XLEN-1:0]   mplier;
  logic [XLEN-1:0]   acc;
  logic [XLEN-1:0]   m_rs2;
  logic [REG_AW-1:0] m_rd;
  logic [CW-1:0]     cnt;
  logic              is_mul;

  assign is_mul = (op == OP_MUL);

  // Multiplier FSM: latch operands at accept, one partial product per clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      m_rs2  <= '0;
      m_rd   <= '0;
      cnt    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept && is_mul) begin
            state  <= MUL;
            mcand  <= rs1_val;
            mplier <= op_b;
            acc    <= '0;
            m_rs2  <= rs2_val;
            m_rd   <= rd_0;
            cnt    <= '0;
          end
        end
        MUL: begin
          if (mplier[0]) acc <= acc + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + CW'(1);
          if (cnt == CNT_LAST) state <= LOAD;
        end
        LOAD:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Output-stage source: product in LOAD, otherwise the ALU.
  always_comb begin
    load              = (accept && !is_mul) || (state == LOAD);
    ld_res            = alu_res;
    ld_rs2            = rs2_val;
    ld_rd             = rd_0;
    ld_flags          = alu_flags;
    if (state == LOAD) begin
      ld_res            = acc;
      ld_rs2            = m_rs2;
      ld_rd             = m_rd;
      ld_flags.negative = acc[XLEN-1];
      ld_flags.overflow = 1'b0;
      ld_flags.zero     = (acc == '0);
    end
  end
`else
  assign state    = IDLE;
  assign load     = accept;
  assign ld_res   = alu_res;
  assign ld_rs2   = rs2_val;
  assign ld_rd    = rd_0;
  assign ld_flags = alu_flags;
`endif

  // EX output register: load new result, else drop valid on handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      alu_result <= '0;
      rs2        <= '0;
      rd_out     <= '0;
      negative   <= 1'b0;
      overflow   <= 1'b0;
      zero       <= 1'b0;
    end else if (load) begin
      out_valid  <= 1'b1;
      alu_result <= ld_res;
      rs2        <= ld_rs2;
      rd_out     <= ld_rd;
      negative   <= ld_flags.negative;
      overflow   <= ld_flags.overflow;
      zero       <= ld_flags.zero;
    end else if (out_ready) begin
      out_valid  <= 1'b0;
    end
  end

endmodule
